syn_pulse_emitter: RTL and testbench
====================================

# syn_pulse_emitter

Synaptic pulse emitter: converts signed weight requests into rate-coded trains of single-cycle `+`/`-` pulses. It sits upstream of the pulse accumulator / neuron block. `plus_pulse_o` and `minus_pulse_o` connect directly to that block's plus/minus pulse inputs, and the same `clk_en` drives both blocks. Requests are queued in a small FIFO, and one train is emitted at a time with a programmable inter-pulse gap.

## Interface
- `WW`, 8: signed weight width. Pulse count is |weight|, at most 2^(WW-1).
- `GAP_CYCLES`, 1: enabled cycles with both pulses low between consecutive pulses of one train. 0 means back-to-back pulses.
- `FIFO_DEPTH`, 4: request queue depth. Power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  step enable, shared with the accumulator.
- `req_valid_i`  in  1  weight request valid.
- `req_ready_o`  out  1  queue can accept.
- `req_weight_i`  in  WW  signed weight, two's complement.
- `abort_i`  in  1  flush the queue and the current train.
- `plus_pulse_o`  out  1  excitatory pulse.
- `minus_pulse_o`  out  1  inhibitory pulse.
- `busy_o`  out  1  a train is in progress (state ≠ IDLE).
- `remaining_o`  out  WW  unsigned pulses still to emit in the current train.

## Operation
- **Handshake:** a request transfers on any `clk` edge with `req_valid_i && req_ready_o`, independent of `clk_en`. `req_ready_o = !fifo_full` and is purely registered-state derived. There is no bypass, so a simultaneous pop does not raise ready in the same cycle.
- **Magnitude:** computed at pop as an unsigned WW-bit value. -2^(WW-1) yields 2^(WW-1), with no saturation. Sign is captured into `neg_q`.
- **FSM:** states IDLE, EMIT, GAP. All transitions require `clk_en=1`, except abort and reset.
  - IDLE: if the FIFO is non-empty, pop.
    - Magnitude 0: discard, stay IDLE. No pulse, `busy_o` stays 0.
    - Otherwise: load `cnt=|w|` and go to EMIT.
  - EMIT: drive the pulse register (`plus` if `!neg_q`, else `minus`) high and decrement `cnt`.
    - `cnt` becomes 0: go to IDLE.
    - Else if `GAP_CYCLES=0`: stay in EMIT.
    - Else: load `gap=GAP_CYCLES` and go to GAP.
  - GAP: decrement `gap`. When `gap` reaches 0, go to EMIT.
- **Pulse outputs:** registered and updated only on `clk_en` edges. Each pulse is high for exactly one enabled cycle and is cleared on the next enabled edge. `plus_pulse_o` and `minus_pulse_o` are never both high.
- **Abort:** `abort_i` is honoured on any edge regardless of `clk_en`. It empties the FIFO, clears `cnt` and `gap`, clears both pulses, and forces IDLE. A request presented in the same cycle as abort is dropped. Abort has priority over push and pop.
- `remaining_o = cnt`. It is 0 in IDLE.

## Timing
- **Reset:** all outputs are 0 except `req_ready_o=1`. FIFO is empty, state is IDLE. Reset during a train ends it with no further pulses.
- **Latency** (`clk_en` held 1, queue empty): request accepted at edge k, popped at k+1, first pulse high after edge k+2.
- **Pulse spacing:** rising edges are `GAP_CYCLES+1` enabled cycles apart.
- **Between trains:** after the last pulse of a train (state goes IDLE), the next train's first pulse follows 2 enabled cycles later.
- **`clk_en` low:** FSM, counters and pulse registers hold. Handshake and abort remain live.

## Structure
- Shared package `snn_pulse_pkg`:
  - `pe_state_t` enum (IDLE, EMIT, GAP).
  - Pulse-pair struct `{plus, minus}`, reused by the accumulator's testbench.
  - `sat` bound constants.
- Sub-module `pulse_req_fifo`:
  - Synchronous FIFO of WW-bit entries with flush.
  - Count-based full/empty, pointers wrap modulo `FIFO_DEPTH`.
- Top level holds the FSM, `cnt`, `gap`, `neg_q` and the pulse registers.

## Test plan
- Weight +3, `GAP_CYCLES=1`, `clk_en`=1 → `plus_pulse_o` high in cycles k+3, k+5, k+7 (after edges k+2, k+4, k+6). `minus_pulse_o` stays 0. `busy_o` then returns to 0.
- Weight -2, then weight 0, then +1, pushed back-to-back:
  - Two minus pulses, then nothing for the 0 entry (`busy_o` stays 0 during it), then one plus pulse.
  - A downstream accumulator reads -1.
- Push 5 requests with the FSM stalled (`clk_en`=0) → 4 accepted, `req_ready_o`=0 on the 5th. Raise `clk_en` → ready returns after the first pop.
- Weight -128 (`WW=8`), `GAP_CYCLES=0` → exactly 128 consecutive minus pulses. `remaining_o` counts 128 down to 0.
- `clk_en` toggling 1,0,1,0 during weight +2 → each pulse persists across the disabled cycle. The accumulator counts exactly 2.
- Weight +5 with 2 queued requests; assert `abort_i` after the 2nd pulse → no further pulses, `req_ready_o`=1, FIFO empty. Repeat using `rst` instead of abort → same result.

Source files
------------

// File: rtl/snn_pulse_pkg.sv
// Shared types for the synaptic pulse emitter and the pulse accumulator.
// The pulse-pair struct is also used by the accumulator's bench.
package snn_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } pe_state_t;

    typedef struct packed {
        logic plus;
        logic minus;
    } pulse_pair_t;

    localparam int ACC_W = 16;
    localparam int signed SAT_MAX = (2 ** (ACC_W - 1)) - 1;
    localparam int signed SAT_MIN = -(2 ** (ACC_W - 1));

endpackage

// File: rtl/pulse_req_fifo.sv
// Weight request queue with flush.
// Occupancy is count-based; pointers wrap naturally at a power-of-two depth.
module pulse_req_fifo #(
    parameter int WW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [WW-1:0] wdata,
    output logic [WW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/syn_pulse_emitter.sv
// Turns queued signed weights into rate-coded trains of +/- pulses,
// one train at a time, with a fixed gap between pulses of a train.
module syn_pulse_emitter #(
    parameter int WW         = 8,
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [WW-1:0] req_weight_i,
    input  logic          abort_i,
    output logic          plus_pulse_o,
    output logic          minus_pulse_o,
    output logic          busy_o,
    output logic [WW-1:0] remaining_o
);

    import snn_pulse_pkg::*;

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    pe_state_t     state_q, state_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          neg_q, neg_d;
    pulse_pair_t   pulse_q, pulse_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [WW-1:0] head;
    logic [WW-1:0] mag;

    // Two's-complement negate; the most negative weight maps to 2^(WW-1).
    assign mag = head[WW-1] ? (~head + 1'b1) : head;

    pulse_req_fifo #(
        .WW    (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_i),
        .push  (req_valid_i && req_ready_o),
        .pop   (fifo_pop),
        .wdata (req_weight_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        neg_d    = neg_q;
        pulse_d  = pulse_q;
        fifo_pop = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            gap_d   = '0;
            pulse_d = '0;
        end else if (clk_en) begin
            pulse_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        neg_d    = head[WW-1];
                        cnt_d    = mag;
                        if (mag != '0) begin
                            state_d = EMIT;
                        end
                    end
                end
                EMIT: begin
                    pulse_d.plus  = !neg_q;
                    pulse_d.minus = neg_q;
                    cnt_d         = cnt_q - 1'b1;
                    if (cnt_q == WW'(1)) begin
                        state_d = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = EMIT;
                    end else begin
                        gap_d   = GW'(GAP_CYCLES);
                        state_d = GAP;
                    end
                end
                GAP: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GW'(1)) begin
                        state_d = EMIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            neg_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            neg_q   <= neg_d;
            pulse_q <= pulse_d;
        end
    end

    assign req_ready_o   = !fifo_full;
    assign plus_pulse_o  = pulse_q.plus;
    assign minus_pulse_o = pulse_q.minus;
    assign busy_o        = (state_q != IDLE);
    assign remaining_o   = cnt_q;

endmodule

// File: tb/tb_syn_pulse_emitter.sv
// Directed bench: per-cycle vector table plus hand sequences for
// queue-full, back-to-back -128 train, abort and mid-train reset.
module tb_syn_pulse_emitter;

    typedef struct {
        logic       ce;
        logic       vld;
        logic [7:0] w;
        logic       pl;
        logic       mi;
        logic       bsy;
        logic       rdy;
        logic [7:0] rem;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       req_valid;
    logic       req_valid0;
    logic [7:0] weight;
    logic       abort;

    logic       ready, plus, minus, busy;
    logic [7:0] rem;
    logic       ready0, plus0, minus0, busy0;
    logic [7:0] rem0;

    int   errors;
    int   checks;
    int   acc;
    logic acc_clr;
    vec_t tbl [26];

    syn_pulse_emitter #(
        .WW         (8),
        .GAP_CYCLES (1),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .req_valid_i   (req_valid),
        .req_ready_o   (ready),
        .req_weight_i  (weight),
        .abort_i       (abort),
        .plus_pulse_o  (plus),
        .minus_pulse_o (minus),
        .busy_o        (busy),
        .remaining_o   (rem)
    );

    syn_pulse_emitter #(
        .WW         (8),
        .GAP_CYCLES (0),
        .FIFO_DEPTH (4)
    ) u_dut0 (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .req_valid_i   (req_valid0),
        .req_ready_o   (ready0),
        .req_weight_i  (weight),
        .abort_i       (abort),
        .plus_pulse_o  (plus0),
        .minus_pulse_o (minus0),
        .busy_o        (busy0),
        .remaining_o   (rem0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream accumulator: samples the pulse pair on enabled edges.
    always @(posedge clk) begin
        if (acc_clr) begin
            acc <= 0;
        end else if (clk_en) begin
            acc <= acc + int'(plus) - int'(minus);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
    endtask

    function automatic vec_t mk(input int ce, input int vld, input int w,
                                input int pl, input int mi, input int bsy,
                                input int rdy, input int rm);
        vec_t v;
        v.ce  = 1'(ce);
        v.vld = 1'(vld);
        v.w   = 8'(w);
        v.pl  = 1'(pl);
        v.mi  = 1'(mi);
        v.bsy = 1'(bsy);
        v.rdy = 1'(rdy);
        v.rem = 8'(rm);
        return v;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            clk_en    = tbl[i].ce;
            req_valid = tbl[i].vld;
            weight    = tbl[i].w;
            step();
            check($sformatf("row%0d", i),
                  {20'd0, plus, minus, busy, ready, rem},
                  {20'd0, tbl[i].pl, tbl[i].mi, tbl[i].bsy,
                   tbl[i].rdy, tbl[i].rem});
        end
        req_valid = 1'b0;
        clk_en    = 1'b1;
    endtask

    task automatic run_abort(input bit use_rst);
        string tag;
        tag = use_rst ? "rst" : "abort";
        clk_en = 1'b1;
        clear_acc();
        weight    = 8'd5;
        req_valid = 1'b1;
        step();
        weight = 8'd1;
        step();
        step();
        req_valid = 1'b0;
        check({tag, "_p1"}, {31'd0, plus}, 32'd1);
        step();
        step();
        check({tag, "_p2"}, {23'd0, plus, rem}, {23'd0, 1'b1, 8'd3});
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        step();
        rst   = 1'b0;
        abort = 1'b0;
        check({tag, "_clean"}, {20'd0, plus, minus, busy, ready, rem},
              {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
        for (int i = 0; i < 10; i++) begin
            step();
            check({tag, "_quiet"}, {28'd0, plus, minus, busy, ready},
                  32'd1);
        end
        check({tag, "_acc"}, acc, 32'd2);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        clk_en     = 1'b1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        weight     = 8'd0;
        abort      = 1'b0;
        acc_clr    = 1'b1;

        // +3 train, gap 1
        tbl[0]  = mk(1, 1, 3,  0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 0, 0,  0, 0, 1, 1, 3);
        tbl[2]  = mk(1, 0, 0,  1, 0, 1, 1, 2);
        tbl[3]  = mk(1, 0, 0,  0, 0, 1, 1, 2);
        tbl[4]  = mk(1, 0, 0,  1, 0, 1, 1, 1);
        tbl[5]  = mk(1, 0, 0,  0, 0, 1, 1, 1);
        tbl[6]  = mk(1, 0, 0,  1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0,  0, 0, 0, 1, 0);
        // -2, 0, +1 back-to-back
        tbl[8]  = mk(1, 1, -2, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1, 0,  0, 0, 1, 1, 2);
        tbl[10] = mk(1, 1, 1,  0, 1, 1, 1, 1);
        tbl[11] = mk(1, 0, 0,  0, 0, 1, 1, 1);
        tbl[12] = mk(1, 0, 0,  0, 1, 0, 1, 0);
        tbl[13] = mk(1, 0, 0,  0, 0, 0, 1, 0);
        tbl[14] = mk(1, 0, 0,  0, 0, 1, 1, 1);
        tbl[15] = mk(1, 0, 0,  1, 0, 0, 1, 0);
        tbl[16] = mk(1, 0, 0,  0, 0, 0, 1, 0);
        // +2 with clk_en toggling
        tbl[17] = mk(1, 1, 2,  0, 0, 0, 1, 0);
        tbl[18] = mk(1, 0, 0,  0, 0, 1, 1, 2);
        tbl[19] = mk(1, 0, 0,  1, 0, 1, 1, 1);
        tbl[20] = mk(0, 0, 0,  1, 0, 1, 1, 1);
        tbl[21] = mk(1, 0, 0,  0, 0, 1, 1, 1);
        tbl[22] = mk(0, 0, 0,  0, 0, 1, 1, 1);
        tbl[23] = mk(1, 0, 0,  1, 0, 0, 1, 0);
        tbl[24] = mk(0, 0, 0,  1, 0, 0, 1, 0);
        tbl[25] = mk(1, 0, 0,  0, 0, 0, 1, 0);

        step();
        step();
        check("reset", {20'd0, plus, minus, busy, ready, rem}, 32'h100);
        check("reset0", {20'd0, plus0, minus0, busy0, ready0, rem0},
              32'h100);
        rst     = 1'b0;
        acc_clr = 1'b0;

        run_rows(0, 7);
        check("acc_plus3", acc, 32'd3);
        clear_acc();
        run_rows(8, 16);
        check("acc_mixed", acc, -32'sd1);
        clear_acc();
        run_rows(17, 25);
        check("acc_ce_toggle", acc, 32'd2);

        // Queue fills while the FSM is stalled
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            weight    = 8'(i + 1);
            req_valid = 1'b1;
            check($sformatf("full_rdy%0d", i), {31'd0, ready},
                  {31'd0, (i < 4)});
            step();
        end
        req_valid = 1'b0;
        check("full_hold", {30'd0, ready, busy}, 32'd0);
        clk_en = 1'b1;
        step();
        check("full_pop", {22'd0, ready, busy, rem}, {22'd0, 2'b11, 8'd1});
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("full_abort", {20'd0, plus, minus, busy, ready, rem},
              32'h100);

        // -128 with no gap on the second instance
        weight     = 8'h80;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        step();
        check("m128_load", {23'd0, busy0, rem0}, {23'd0, 1'b1, 8'd128});
        for (int j = 1; j <= 128; j++) begin
            step();
            check($sformatf("m128_p%0d", j),
                  {22'd0, minus0, plus0, rem0},
                  {22'd0, 1'b1, 1'b0, 8'(128 - j)});
        end
        check("m128_idle", {31'd0, busy0}, 32'd0);
        step();
        check("m128_end", {30'd0, minus0, busy0}, 32'd0);

        run_abort(1'b0);
        run_abort(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
